apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 159 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-transfer command/response to APB master bridge with a per-transfer
// pready timeout; all APB and response outputs come straight from flops.
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_WIDTH-1:0]     prdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e state_q, state_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

  logic cmd_hs;
  logic access_done;
  logic access_tmo;

  assign cmd_hs      = cmd_valid && cmd_ready_q;
  assign access_done = (state_q == ACCESS) && pready;
  // pready wins over a timeout firing in the same cycle
  assign access_tmo  = (state_q == ACCESS) && !pready && (wait_cnt_q == CNT_LAST);

  // State and output registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_hs) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (access_done || access_tmo) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values, decoded from the upcoming state so they land with it
  always_comb begin
    cmd_ready_d   = (state_d == IDLE);
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    rsp_valid_d   = (state_d == RESP);
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    if (cmd_hs) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_write ? cmd_wdata : '0;
      pstrb_d  = cmd_write ? cmd_strb : '0;
    end

    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    if (access_done) begin
      rsp_rdata_d   = pwrite_q ? '0 : prdata;
      rsp_err_d     = pslverr;
      rsp_timeout_d = 1'b0;
    end else if (access_tmo) begin
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: bench-driven APB slave responses and a
// response scoreboard filled at command issue and drained at rsp_valid.
module tb_apb_master_bridge;

  localparam int unsigned TIMEOUT = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  apb_master_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pready     (pready),
    .pslverr    (pslverr),
    .prdata     (prdata)
  );

  always #5 pclk = ~pclk;

  // Advance one clock and land 1ns after the edge, where outputs are sampled and inputs driven
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input logic serr,
                         input logic [31:0] rdata, input int rsp_delay);
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    int          acc;
    int          exp_acc;
    rsp_t        exp_r;
    rsp_t        sb;
    rsp_t        got;
    exp_wd = wr ? wdata : 32'h0;
    exp_st = wr ? strb : 4'h0;
    if (waits >= int'(TIMEOUT)) begin
      exp_acc = int'(TIMEOUT);
      exp_r   = '{rdata: 32'h0, err: 1'b1, tmo: 1'b1};
    end else begin
      exp_acc = waits + 1;
      exp_r   = '{rdata: (wr ? 32'h0 : rdata), err: serr, tmo: 1'b0};
    end

    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) step();
    chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    exp_q.push_back(exp_r);
    step();

    chk("setup_ctrl", 128'({psel, penable, cmd_ready}), 128'(3'b100));
    chk("setup_fields", {59'h0, paddr, pwrite, pwdata, pstrb}, {59'h0, addr, wr, exp_wd, exp_st});
    // keep presenting junk commands; they must not disturb the transfer
    cmd_addr  = ~addr;
    cmd_write = ~wr;
    cmd_wdata = ~wdata;
    cmd_strb  = ~strb;
    pready    = 1'b0;
    pslverr   = 1'b1;
    prdata    = 32'hBAD0_BAD0;
    step();

    acc = 0;
    while (psel === 1'b1 && penable === 1'b1 && acc < 40) begin
      chk("access_fields", {59'h0, paddr, pwrite, pwdata, pstrb},
          {59'h0, addr, wr, exp_wd, exp_st});
      pready  = (acc == waits);
      pslverr = (acc == waits) ? serr : 1'b1;
      prdata  = (acc == waits) ? rdata : 32'hBAD0_BAD0;
      acc++;
      step();
    end
    cmd_valid = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    chk("access_cycles", 128'(acc), 128'(exp_acc));
    chk("end_psel_penable", 128'({psel, penable}), 128'(2'b00));
    chk("rsp_valid", 128'(rsp_valid), 128'(1));
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 128'(0), 128'(1));
      sb = exp_r;
    end else begin
      sb = exp_q.pop_front();
    end
    got = '{rdata: rsp_rdata, err: rsp_err, tmo: rsp_timeout};
    chk("rsp_fields", 128'(got), 128'(sb));

    for (int d = 0; d < rsp_delay; d++) begin
      step();
      chk("hold_valid", 128'(rsp_valid), 128'(1));
      chk("hold_fields", 128'({rsp_rdata, rsp_err, rsp_timeout}), 128'(sb));
      chk("hold_ready_psel", 128'({cmd_ready, psel}), 128'(2'b00));
    end

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_rsp", 128'({rsp_valid, cmd_ready, psel}), 128'(3'b010));
  endtask

  initial begin
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_strb  = 4'h0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'h0;

    step();
    step();
    chk("reset_ctrl", 128'({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}),
        128'(7'b0));
    chk("reset_data", {28'h0, paddr, pwdata, pstrb, rsp_rdata}, 128'(0));
    preset = 1'b0;
    step();
    chk("release_cmd_ready", 128'(cmd_ready), 128'(1));

    // zero-wait write
    do_xfer(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h1111_2222, 0);
    // read with two wait states
    do_xfer(1'b0, 32'h0000_1238, 32'h5555_5555, 4'hF, 2, 1'b0, 32'hA5A5_0001, 0);
    // write with slave error
    do_xfer(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'h0, 0);
    // pready never arrives: timeout
    do_xfer(1'b0, 32'h0000_0080, 32'h0, 4'h0, 100, 1'b0, 32'h7777_7777, 0);
    // pready on the last allowed cycle: normal completion
    do_xfer(1'b0, 32'h0000_0084, 32'h0, 4'h0, 15, 1'b0, 32'hCAFE_0015, 0);
    // back-pressured responses
    do_xfer(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 1'b0, 32'h1357_9BDF, 5);
    do_xfer(1'b1, 32'hFFFF_FFFC, 32'h89AB_CDEF, 4'h5, 3, 1'b0, 32'h0, 5);
    // read with slave error keeps read data
    do_xfer(1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 1'b1, 32'h1234_5678, 2);

    // reset in the middle of an ACCESS phase
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) step();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0300;
    cmd_wdata = 32'hFEED_FACE;
    cmd_strb  = 4'hF;
    step();
    cmd_valid = 1'b0;
    pready    = 1'b0;
    step();
    step();
    chk("pre_reset_access", 128'({psel, penable}), 128'(2'b11));
    preset = 1'b1;
    step();
    chk("midreset_ctrl", 128'({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}),
        128'(7'b0));
    chk("midreset_data", {28'h0, paddr, pwdata, pstrb, rsp_rdata}, 128'(0));
    preset = 1'b0;
    exp_q.delete();
    step();
    chk("midreset_release", 128'({cmd_ready, rsp_valid, psel}), 128'(3'b100));
    do_xfer(1'b0, 32'h0000_0304, 32'h0, 4'h0, 1, 1'b0, 32'h0F0F_F0F0, 0);

    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
